fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares one FIFO write port among NUM_REQ producers. Each producer presents multi-beat packets over a valid/ready handshake. Once a packet starts, the arbiter locks onto that producer until its last beat is written, so packets are never interleaved in the FIFO. Write enables are gated with the FIFO's full flag, so no beat is ever dropped or duplicated.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/rr_picker.sv | 40 ++++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // Explicit compare-and-wrap so non-power-of-two producer counts stay in range.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned num_req);
        return (ptr >= num_req - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate requests by ptr, priority-encode, un-rotate.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     idx,
    output logic               found
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDW-1:0]       off;
    logic [IDW:0]         sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[NUM_REQ-1:0];
        off   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off   = IDW'(i);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IDW+1)'(NUM_REQ)) begin
            sum = sum - (IDW+1)'(NUM_REQ);
        end
        idx = sum[IDW-1:0];
        gnt = '0;
        if (found) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; locks onto a producer for a whole packet.
//   state    | meaning
//   ARB_IDLE | no packet in progress, round-robin pick among valid producers
//   ARB_LOCK | packet from gnt_q in progress, only that producer is served
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic [IDW-1:0]                grant_id_o,
    output logic                          locked_o,
    output logic [31:0]                   pkt_count_o
);

    arb_state_e         state, state_d;
    logic [IDW-1:0]     rr_ptr, rr_ptr_d;
    logic [IDW-1:0]     gnt_q, gnt_d;
    logic [31:0]        pkt_count, pkt_count_d;

    logic [NUM_REQ-1:0] sel_onehot;
    logic [IDW-1:0]     sel_idx;
    logic               sel_found;
    logic [IDW-1:0]     cur_idx;
    logic               beat_last;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_picker (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .gnt   (sel_onehot),
        .idx   (sel_idx),
        .found (sel_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            gnt_q     <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            gnt_q     <= gnt_d;
            pkt_count <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_d       = gnt_q;
        pkt_count_d = pkt_count;
        case (state)
            ARB_IDLE: begin
                if (fifo_wr_en_o) begin
                    gnt_d = sel_idx;
                    if (beat_last) begin
                        rr_ptr_d    = IDW'(rr_next(32'(sel_idx), NUM_REQ));
                        pkt_count_d = pkt_count + 32'd1;
                    end else begin
                        state_d = ARB_LOCK;
                    end
                end
            end
            ARB_LOCK: begin
                if (fifo_wr_en_o && beat_last) begin
                    state_d     = ARB_IDLE;
                    rr_ptr_d    = IDW'(rr_next(32'(gnt_q), NUM_REQ));
                    pkt_count_d = pkt_count + 32'd1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Ready is purely combinational from full so a stall takes effect in the same cycle.
    always_comb begin
        req_ready_o    = '0;
        cur_idx        = (state == ARB_LOCK) ? gnt_q : sel_idx;
        if (!rst) begin
            case (state)
                ARB_IDLE: if (sel_found && !fifo_full_i) req_ready_o = sel_onehot;
                ARB_LOCK: req_ready_o[gnt_q] = ~fifo_full_i;
                default:  req_ready_o = '0;
            endcase
        end
        fifo_wr_en_o   = |(req_valid_i & req_ready_o);
        beat_last      = req_last_i[cur_idx];
        fifo_wr_data_o = fifo_wr_en_o ? req_data_i[cur_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    assign grant_id_o  = gnt_q;
    assign locked_o    = (state == ARB_LOCK);
    assign pkt_count_o = pkt_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: 4-producer instance plus a 3-producer wrap instance.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst;

    logic [3:0]   valid, last, ready;
    logic [127:0] data;
    logic         full, wr_en, locked;
    logic [31:0]  wr_data, pkt;
    logic [1:0]   grant;

    logic [2:0]   v3, l3, r3;
    logic [95:0]  d3;
    logic         f3, we3, lk3;
    logic [31:0]  wd3, pk3;
    logic [1:0]   g3;

    int n_cmp = 0;
    int n_err = 0;
    int n_wr  = 0;
    int wr_base;

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) n_wr <= n_wr + 1;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(valid), .req_last_i(last), .req_data_i(data),
        .req_ready_o(ready), .fifo_full_i(full),
        .fifo_wr_en_o(wr_en), .fifo_wr_data_o(wr_data),
        .grant_id_o(grant), .locked_o(locked), .pkt_count_o(pkt)
    );

    fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid_i(v3), .req_last_i(l3), .req_data_i(d3),
        .req_ready_o(r3), .fifo_full_i(f3),
        .fifo_wr_en_o(we3), .fifo_wr_data_o(wd3),
        .grant_id_o(g3), .locked_o(lk3), .pkt_count_o(pk3)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int k, input int b);
        return 32'hA000_0000 | (32'(k) << 8) | 32'(b);
    endfunction

    task automatic set_d(input int k, input logic [31:0] v);
        data[k*32 +: 32] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; full = 1'b0; f3 = 1'b0;
        valid = 4'hF; last = 4'hF; data = '0;
        v3 = '0; l3 = '0; d3 = '0;
        for (int k = 0; k < 4; k++) set_d(k, mk(k, 0));
        #2;
        check_eq("rst_ready", 64'(ready), 64'h0);
        check_eq("rst_wr_en", 64'(wr_en), 64'h0);
        tick(); tick();
        check_eq("rst_locked", 64'(locked), 64'h0);
        check_eq("rst_grant", 64'(grant), 64'h0);
        check_eq("rst_pkt", 64'(pkt), 64'h0);

        // fairness: every producer always has a single-beat packet
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_eq($sformatf("rr_ready_%0d", i), 64'(ready), 64'(4'b0001 << (i % 4)));
            check_eq($sformatf("rr_data_%0d", i), 64'(wr_data), 64'(mk(i % 4, 0)));
            tick();
        end
        check_eq("rr_pkt6", 64'(pkt), 64'd6);
        check_eq("rr_grant", 64'(grant), 64'd1);

        // atomicity: producer 2 three-beat packet vs producer 1 always valid
        valid = 4'b0110; last = 4'b0010;
        set_d(2, mk(2, 0)); set_d(1, mk(1, 9));
        settle();
        check_eq("at_ready0", 64'(ready), 64'b0100);
        check_eq("at_data0", 64'(wr_data), 64'(mk(2, 0)));
        tick();
        set_d(2, mk(2, 1));
        settle();
        check_eq("at_lock1", 64'(locked), 64'd1);
        check_eq("at_ready1", 64'(ready), 64'b0100);
        check_eq("at_data1", 64'(wr_data), 64'(mk(2, 1)));
        tick();
        set_d(2, mk(2, 2)); last = 4'b0110;
        settle();
        check_eq("at_lock2", 64'(locked), 64'd1);
        check_eq("at_data2", 64'(wr_data), 64'(mk(2, 2)));
        tick();
        valid = 4'b0010;
        settle();
        check_eq("at_unlock", 64'(locked), 64'd0);
        check_eq("at_ready_p1", 64'(ready), 64'b0010);
        check_eq("at_data_p1", 64'(wr_data), 64'(mk(1, 9)));
        tick();
        check_eq("at_pkt", 64'(pkt), 64'd8);

        // full stall mid-packet on producer 0; producer 3 waits behind the lock
        wr_base = n_wr;
        valid = 4'b0001; last = 4'b0000; set_d(0, mk(0, 0));
        settle();
        check_eq("fs_ready0", 64'(ready), 64'b0001);
        tick();
        valid = 4'b1001; last = 4'b1000; set_d(0, mk(0, 1)); set_d(3, mk(3, 7));
        settle();
        check_eq("fs_ready1", 64'(ready), 64'b0001);
        check_eq("fs_data1", 64'(wr_data), 64'(mk(0, 1)));
        tick();
        full = 1'b1; set_d(0, mk(0, 2));
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("fs_stall_ready_%0d", i), 64'(ready), 64'h0);
            check_eq($sformatf("fs_stall_wr_%0d", i), 64'(wr_en), 64'h0);
            check_eq($sformatf("fs_stall_grant_%0d", i), 64'(grant), 64'h0);
            tick();
        end
        full = 1'b0;
        settle();
        check_eq("fs_data2", 64'(wr_data), 64'(mk(0, 2)));
        tick();
        last = 4'b1001; set_d(0, mk(0, 3));
        settle();
        check_eq("fs_ready3", 64'(ready), 64'b0001);
        check_eq("fs_data3", 64'(wr_data), 64'(mk(0, 3)));
        tick();
        check_eq("fs_writes", 64'(n_wr - wr_base), 64'd4);
        check_eq("fs_pkt", 64'(pkt), 64'd9);
        valid = 4'b1000;
        settle();
        check_eq("fs_p3_ready", 64'(ready), 64'b1000);
        tick();

        // bubble: producer 3 locked, drops valid with a stray last while producer 0 waits
        valid = 4'b1000; last = 4'b0000; set_d(3, mk(3, 0));
        settle();
        check_eq("bb_ready0", 64'(ready), 64'b1000);
        tick();
        valid = 4'b0001; last = 4'b1001; set_d(0, mk(0, 5));
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq($sformatf("bb_wr_%0d", i), 64'(wr_en), 64'h0);
            check_eq($sformatf("bb_lock_%0d", i), 64'(locked), 64'd1);
            tick();
        end
        valid = 4'b1001; set_d(3, mk(3, 1));
        settle();
        check_eq("bb_ready_last", 64'(ready), 64'b1000);
        check_eq("bb_data_last", 64'(wr_data), 64'(mk(3, 1)));
        tick();
        valid = 4'b0001;
        settle();
        check_eq("bb_p0_ready", 64'(ready), 64'b0001);
        tick();
        check_eq("bb_pkt", 64'(pkt), 64'd12);

        // idle with full: winner not taken, pointer must not move
        valid = 4'b0110; last = 4'b0110; full = 1'b1;
        settle();
        check_eq("if_wr", 64'(wr_en), 64'h0);
        tick();
        full = 1'b0;
        settle();
        check_eq("if_ready", 64'(ready), 64'b0010);
        tick();

        // reset mid-packet
        valid = 4'b0010; last = 4'b0000;
        settle();
        check_eq("rm_ready0", 64'(ready), 64'b0010);
        tick();
        check_eq("rm_locked", 64'(locked), 64'd1);
        rst = 1'b1; valid = 4'b0000;
        tick();
        rst = 1'b0;
        check_eq("rm_unlock", 64'(locked), 64'd0);
        check_eq("rm_grant", 64'(grant), 64'd0);
        check_eq("rm_pkt", 64'(pkt), 64'd0);
        valid = 4'b0010; last = 4'b0010;
        settle();
        check_eq("rm_new_ready", 64'(ready), 64'b0010);
        check_eq("rm_new_wr", 64'(wr_en), 64'd1);
        tick();
        check_eq("rm_new_pkt", 64'(pkt), 64'd1);
        valid = 4'b0000;

        // wrap on the 3-producer instance
        v3 = 3'b100; l3 = 3'b111; d3[64 +: 32] = mk(2, 3); d3[0 +: 32] = mk(0, 3);
        settle();
        check_eq("wr_p2_ready", 64'(r3), 64'b100);
        check_eq("wr_p2_data", 64'(wd3), 64'(mk(2, 3)));
        tick();
        v3 = 3'b101;
        settle();
        check_eq("wr_p0_ready", 64'(r3), 64'b001);
        check_eq("wr_p0_data", 64'(wd3), 64'(mk(0, 3)));
        tick();
        settle();
        check_eq("wr_p2_again", 64'(r3), 64'b100);
        tick();
        check_eq("wr_pkt", 64'(pk3), 64'd3);
        check_eq("wr_grant", 64'(g3), 64'd2);
        v3 = 3'b000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
